wb_arbiter: RTL and testbench

//  Writeback stage driving the integer register file's single write port (wr_en/rd_addr/rd_data).

---
 rtl/wb_arbiter_if.sv | 43 ++++
 rtl/wb_arbiter.sv | 126 ++++++++++++
 tb/tb_wb_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus bundle: ALU and load result handshakes, issue scoreboard
// port, and the registered register-file write port.
interface wb_arbiter_if #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int LQ_DEPTH = 4
);
  localparam int CW = $clog2(LQ_DEPTH) + 1;

  logic              alu_valid_in;
  logic              alu_ready_out;
  logic [AW-1:0]     alu_rd_addr_in;
  logic [XLEN-1:0]   alu_data_in;
  logic              ld_valid_in;
  logic              ld_ready_out;
  logic [AW-1:0]     ld_rd_addr_in;
  logic [XLEN-1:0]   ld_data_in;
  logic              issue_en_in;
  logic [AW-1:0]     issue_rd_in;
  logic [2**AW-1:0]  busy_out;
  logic              wr_en_out;
  logic [AW-1:0]     rd_addr_out;
  logic [XLEN-1:0]   rd_data_out;
  logic [CW-1:0]     lq_count_out;

  // Arbiter side: consumes results and issue info, drives the write port.
  modport slave (
    input  alu_valid_in, alu_rd_addr_in, alu_data_in,
    input  ld_valid_in, ld_rd_addr_in, ld_data_in,
    input  issue_en_in, issue_rd_in,
    output alu_ready_out, ld_ready_out, busy_out,
    output wr_en_out, rd_addr_out, rd_data_out, lq_count_out
  );

  // Environment side: producers, issue logic and register-file observer.
  modport master (
    output alu_valid_in, alu_rd_addr_in, alu_data_in,
    output ld_valid_in, ld_rd_addr_in, ld_data_in,
    output issue_en_in, issue_rd_in,
    input  alu_ready_out, ld_ready_out, busy_out,
    input  wr_en_out, rd_addr_out, rd_data_out, lq_count_out
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU results and FIFO-buffered load results onto the single
// register-file write port, and keeps the busy scoreboard. WB_STALL_CNT_EN adds a stall counter.
module wb_arbiter #(
  parameter int XLEN     = 32,
  parameter int AW       = 5,
  parameter int LQ_DEPTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  wb_arbiter_if.slave bus
`ifdef WB_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt_out
`endif
);
  localparam int PW = $clog2(LQ_DEPTH);
  localparam int CW = PW + 1;
  localparam int NR = 2**AW;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } lq_entry_t;

  lq_entry_t       mem_q [LQ_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wr_en_q, wr_en_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [XLEN-1:0] rd_data_q, rd_data_d;
  logic [NR-1:0]   busy_q, busy_d;

  logic      full, enq, deq, commit;
  lq_entry_t head, commit_e;

  assign full = (count_q == CW'(LQ_DEPTH));
  assign head = mem_q[rd_ptr_q];
  assign enq  = bus.ld_valid_in && !full;

  // Full FIFO forces the head out ahead of the ALU so loads cannot starve.
  // NOTE: every combinational output gets a default first, so no path infers a latch.
  always_comb begin
    deq      = 1'b0;
    commit   = 1'b0;
    commit_e = head;
    if (full) begin
      deq    = 1'b1;
      commit = 1'b1;
    end else if (bus.alu_valid_in) begin
      commit   = 1'b1;
      commit_e = '{rd: bus.alu_rd_addr_in, data: bus.alu_data_in};
    end else if (count_q != '0) begin
      deq    = 1'b1;
      commit = 1'b1;
    end
  end

  always_comb begin
    wr_ptr_d  = enq ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = deq ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q + CW'(enq) - CW'(deq);
    // x0 results are consumed but never reach the register file.
    wr_en_d   = commit && (commit_e.rd != '0);
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (wr_en_d) begin
      rd_addr_d = commit_e.rd;
      rd_data_d = commit_e.data;
    end
    // Clear first, then set, so a same-cycle younger issue wins.
    busy_d = busy_q;
    if (wr_en_q)         busy_d[rd_addr_q]       = 1'b0;
    if (bus.issue_en_in) busy_d[bus.issue_rd_in] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
      busy_q    <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      busy_q    <= busy_d;
    end
  end

  // NOTE: the storage array has no reset; occupancy alone decides which entries are valid.
  always_ff @(posedge clk_in) begin
    if (enq) mem_q[wr_ptr_q] <= '{rd: bus.ld_rd_addr_in, data: bus.ld_data_in};
  end

`ifdef WB_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.alu_valid_in && full && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) stall_q <= '0;
    else           stall_q <= stall_d;
  end

  assign stall_cnt_out = stall_q;
`endif

  assign bus.alu_ready_out = !full;
  assign bus.ld_ready_out  = !full;
  assign bus.busy_out      = busy_q;
  assign bus.wr_en_out     = wr_en_q;
  assign bus.rd_addr_out   = rd_addr_q;
  assign bus.rd_data_out   = rd_data_q;
  assign bus.lq_count_out  = count_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of the writeback rules.
module tb_wb_arbiter;
  localparam int XLEN     = 32;
  localparam int AW       = 5;
  localparam int LQ_DEPTH = 4;
  localparam int NR       = 2**AW;

  typedef struct {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } res_t;

  logic clk_in;
  logic rst_n_in;
  wb_arbiter_if #(.XLEN(XLEN), .AW(AW), .LQ_DEPTH(LQ_DEPTH)) bus ();
`ifdef WB_STALL_CNT_EN
  logic [15:0] stall_cnt_out;
`endif

  wb_arbiter #(.XLEN(XLEN), .AW(AW), .LQ_DEPTH(LQ_DEPTH)) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
`ifdef WB_STALL_CNT_EN
    ,
    .stall_cnt_out (stall_cnt_out)
`endif
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  res_t            lq[$];
  logic [NR-1:0]   m_busy;
  logic            m_wr_en;
  logic [AW-1:0]   m_addr;
  logic [XLEN-1:0] m_data;
  logic [15:0]     m_stall;
  bit              alu_acc, ld_acc;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    lq.delete();
    m_busy  = '0;
    m_wr_en = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_stall = '0;
    alu_acc = 1'b1;
    ld_acc  = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_wr_en"}, 64'(bus.wr_en_out), 64'd0);
    check({tag, "_addr"},  64'(bus.rd_addr_out), 64'd0);
    check({tag, "_data"},  64'(bus.rd_data_out), 64'd0);
    check({tag, "_busy"},  64'(bus.busy_out), 64'd0);
    check({tag, "_count"}, 64'(bus.lq_count_out), 64'd0);
`ifdef WB_STALL_CNT_EN
    check({tag, "_stall"}, 64'(stall_cnt_out), 64'd0);
`endif
  endtask

  task automatic set_idle();
    bus.alu_valid_in   = 1'b0;
    bus.alu_rd_addr_in = '0;
    bus.alu_data_in    = '0;
    bus.ld_valid_in    = 1'b0;
    bus.ld_rd_addr_in  = '0;
    bus.ld_data_in     = '0;
    bus.issue_en_in    = 1'b0;
    bus.issue_rd_in    = '0;
  endtask

  // One clock: called at posedge+1 with inputs already driven; returns at next posedge+1.
  task automatic cycle();
    bit   full, c_v;
    res_t c;
    #1;
    full = (lq.size() == LQ_DEPTH);
    check("alu_ready", 64'(bus.alu_ready_out), 64'(!full));
    check("ld_ready",  64'(bus.ld_ready_out),  64'(!full));
    alu_acc = bus.alu_valid_in && !full;
    ld_acc  = bus.ld_valid_in && !full;
    if (bus.alu_valid_in && full && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
    c_v = 1'b0;
    c   = '{rd: '0, data: '0};
    if (full) begin
      c = lq.pop_front(); c_v = 1'b1;
    end else if (bus.alu_valid_in) begin
      c = '{rd: bus.alu_rd_addr_in, data: bus.alu_data_in}; c_v = 1'b1;
    end else if (lq.size() > 0) begin
      c = lq.pop_front(); c_v = 1'b1;
    end
    if (ld_acc) lq.push_back('{rd: bus.ld_rd_addr_in, data: bus.ld_data_in});
    if (m_wr_en) m_busy[m_addr] = 1'b0;
    if (bus.issue_en_in && bus.issue_rd_in != '0) m_busy[bus.issue_rd_in] = 1'b1;
    m_wr_en = c_v && (c.rd != '0);
    if (m_wr_en) begin
      m_addr = c.rd;
      m_data = c.data;
    end
    @(posedge clk_in);
    #1;
    check("wr_en", 64'(bus.wr_en_out), 64'(m_wr_en));
    if (m_wr_en) begin
      check("rd_addr", 64'(bus.rd_addr_out), 64'(m_addr));
      check("rd_data", 64'(bus.rd_data_out), 64'(m_data));
    end
    check("busy",     64'(bus.busy_out), 64'(m_busy));
    check("lq_count", 64'(bus.lq_count_out), 64'(lq.size()));
`ifdef WB_STALL_CNT_EN
    check("stall_cnt", 64'(stall_cnt_out), 64'(m_stall));
`endif
  endtask

  logic [NR-1:0] busy_snap;

  initial begin
    set_idle();
    model_reset();
    rst_n_in = 1'b1;
    #1 rst_n_in = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;

    // ALU x5 commits one cycle after acceptance
    bus.alu_valid_in = 1'b1; bus.alu_rd_addr_in = 5'd5; bus.alu_data_in = 32'hDEADBEEF;
    cycle();
    check("t1_wr_en", 64'(bus.wr_en_out), 64'd1);
    check("t1_addr",  64'(bus.rd_addr_out), 64'd5);
    check("t1_data",  64'(bus.rd_data_out), 64'hDEADBEEF);
    set_idle();
    cycle();

    // Load x7 after issue: commit two cycles after enqueue, busy clears one later
    bus.issue_en_in = 1'b1; bus.issue_rd_in = 5'd7;
    cycle();
    set_idle();
    bus.ld_valid_in = 1'b1; bus.ld_rd_addr_in = 5'd7; bus.ld_data_in = 32'h1234;
    cycle();
    check("t2_n1_wr_en", 64'(bus.wr_en_out), 64'd0);
    set_idle();
    cycle();
    check("t2_n2_wr_en", 64'(bus.wr_en_out), 64'd1);
    check("t2_n2_data",  64'(bus.rd_data_out), 64'h1234);
    check("t2_n2_busy7", 64'(bus.busy_out[7]), 64'd1);
    cycle();
    check("t2_n3_busy7", 64'(bus.busy_out[7]), 64'd0);

    // FIFO fill under continuous ALU traffic, starvation guard, ALU resume
    for (int i = 0; i < 4; i++) begin
      bus.alu_valid_in   = 1'b1;
      bus.alu_rd_addr_in = AW'(20 + i);
      bus.alu_data_in    = 32'hA000_0000 + 32'(i);
      bus.ld_valid_in    = 1'b1;
      bus.ld_rd_addr_in  = AW'(11 + i);
      bus.ld_data_in     = 32'hB000_0000 + 32'(i);
      cycle();
    end
    check("t3_count_full", 64'(bus.lq_count_out), 64'd4);
    bus.ld_valid_in    = 1'b0;
    bus.alu_rd_addr_in = 5'd24;
    bus.alu_data_in    = 32'hA000_0004;
    cycle();
    check("t3_head_addr", 64'(bus.rd_addr_out), 64'd11);
    check("t3_head_data", 64'(bus.rd_data_out), 64'hB000_0000);
`ifdef WB_STALL_CNT_EN
    check("t3_stall_one", 64'(stall_cnt_out), 64'd1);
`endif
    cycle();
    check("t3_alu_resume", 64'(bus.rd_addr_out), 64'd24);
    set_idle();
    repeat (4) cycle();
    check("t3_drained", 64'(bus.lq_count_out), 64'd0);

    // ALU x0: consumed, no write, busy untouched
    bus.issue_en_in = 1'b1; bus.issue_rd_in = 5'd3;
    cycle();
    set_idle();
    cycle();
    busy_snap = bus.busy_out;
    bus.alu_valid_in = 1'b1; bus.alu_rd_addr_in = '0; bus.alu_data_in = 32'hFFFFFFFF;
    cycle();
    check("t4_wr_en", 64'(bus.wr_en_out), 64'd0);
    check("t4_busy",  64'(bus.busy_out), 64'(busy_snap));
    set_idle();
    cycle();

    // Issue x9 in the cycle x9's write is registered: set wins
    bus.issue_en_in = 1'b1; bus.issue_rd_in = 5'd9;
    cycle();
    set_idle();
    bus.alu_valid_in = 1'b1; bus.alu_rd_addr_in = 5'd9; bus.alu_data_in = 32'h99;
    cycle();
    set_idle();
    bus.issue_en_in = 1'b1; bus.issue_rd_in = 5'd9;
    cycle();
    check("t5_busy9", 64'(bus.busy_out[9]), 64'd1);
    set_idle();
    cycle();

    // Random traffic honouring the hold-while-stalled rule
    alu_acc = 1'b1;
    ld_acc  = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if (!(bus.alu_valid_in && !alu_acc)) begin
        bus.alu_valid_in   = ($urandom_range(0, 9) < 7);
        bus.alu_rd_addr_in = AW'($urandom_range(0, NR-1));
        bus.alu_data_in    = $urandom;
      end
      if (!(bus.ld_valid_in && !ld_acc)) begin
        bus.ld_valid_in   = ($urandom_range(0, 9) < 5);
        bus.ld_rd_addr_in = AW'($urandom_range(0, NR-1));
        bus.ld_data_in    = $urandom;
      end
      bus.issue_en_in = ($urandom_range(0, 3) == 0);
      bus.issue_rd_in = AW'($urandom_range(0, NR-1));
      cycle();
    end
    set_idle();
    repeat (6) cycle();

    // Async reset mid-burst with three loads queued
    for (int i = 0; i < 3; i++) begin
      bus.alu_valid_in   = 1'b1;
      bus.alu_rd_addr_in = AW'(1 + i);
      bus.alu_data_in    = 32'hC000_0000 + 32'(i);
      bus.ld_valid_in    = 1'b1;
      bus.ld_rd_addr_in  = AW'(17 + i);
      bus.ld_data_in     = 32'hD000_0000 + 32'(i);
      bus.issue_en_in    = 1'b1;
      bus.issue_rd_in    = AW'(25 + i);
      cycle();
    end
    check("t6_count3", 64'(bus.lq_count_out), 64'd3);
    #2 rst_n_in = 1'b0;
    #1 check_reset_outputs("t6_async");
    check("t6_alu_ready", 64'(bus.alu_ready_out), 64'd1);
    check("t6_ld_ready",  64'(bus.ld_ready_out), 64'd1);
    set_idle();
    model_reset();
    @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    repeat (3) cycle();
    check("t6_no_spurious", 64'(bus.wr_en_out), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
